// File: rtl/floo_vc_credit_scheduler_if.sv
// floo_vc_credit_scheduler_if: per-VC upstream flits, shared link output and credit return.
interface floo_vc_credit_scheduler_if #(
  parameter int unsigned NumVirtChannels = 2,
  parameter type flit_t = logic
) ();
  logic [NumVirtChannels-1:0] valid_i, ready_o, last_i, valid_o, credit_i, credit_left_o;
  flit_t data_i [NumVirtChannels];
  flit_t data_o;
  logic [NumVirtChannels-1:0][15:0] stall_cnt_o;
  modport master (
    output valid_i, data_i, last_i, credit_i,
    input  ready_o, valid_o, data_o, credit_left_o, stall_cnt_o
  );
  modport slave (
    input  valid_i, data_i, last_i, credit_i,
    output ready_o, valid_o, data_o, credit_left_o, stall_cnt_o
  );
endinterface

// File: rtl/floo_vc_credit_scheduler.sv
// floo_vc_credit_scheduler: credit-based link sharing across VCs with wormhole packet locking.
// Define FLOO_VC_SCHED_STATS_EN to build the per-VC saturating stall counters.
module floo_vc_credit_scheduler #(
  parameter int unsigned NumVirtChannels = 2,
  parameter type flit_t = logic,
  parameter int unsigned NumCredits = 3,
  parameter int unsigned MaxPktLen = 0
) (
  input logic clk_i,
  input logic rst_ni,
  floo_vc_credit_scheduler_if.slave bus
);
  localparam int unsigned CW = $clog2(NumCredits + 1);
  localparam int unsigned IW = $clog2(NumVirtChannels);
  localparam int unsigned PW = (MaxPktLen == 0) ? 16 : $clog2(MaxPktLen + 1);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e r_state, w_state;
  logic [IW-1:0] r_rr, w_rr, r_owner, w_owner, w_gidx;
  logic [PW-1:0] r_pkt, w_pkt;
  logic [CW-1:0] r_cnt [NumVirtChannels];
  logic [NumVirtChannels-1:0] w_elig, w_gnt;
  logic w_any, w_too_long;

  if (NumVirtChannels < 2) begin : g_bad_cfg
    $error("NumVirtChannels must be >= 2");
  end

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (x == IW'(NumVirtChannels - 1)) ? '0 : x + 1'b1;
  endfunction

  // While locked only the owner may use the link; otherwise round-robin from r_rr.
  always_comb begin
    w_gidx = r_owner;
    w_any = 1'b0;
    if (r_state == LOCKED) begin
      w_any = w_elig[r_owner];
    end else begin
      for (int i = NumVirtChannels - 1; i >= 0; i--) begin
        if (w_elig[(int'(r_rr) + i) % NumVirtChannels]) begin
          w_gidx = IW'((int'(r_rr) + i) % NumVirtChannels);
          w_any = 1'b1;
        end
      end
    end
  end

  assign w_gnt = w_any ? ({{(NumVirtChannels-1){1'b0}}, 1'b1} << w_gidx) : '0;
  assign bus.valid_o = w_gnt;
  assign bus.ready_o = w_gnt;
  assign bus.data_o = bus.data_i[w_any ? w_gidx : r_rr];

  always_comb begin
    w_state = r_state;
    w_rr = r_rr;
    w_owner = r_owner;
    w_pkt = r_pkt;
    w_too_long = 1'b0;
    if (w_any) begin
      if (bus.last_i[w_gidx]) begin
        w_state = IDLE;
        w_rr = nxt(w_gidx);
        w_pkt = '0;
      end else begin
        w_state = LOCKED;
        w_owner = w_gidx;
        w_pkt = (r_state == IDLE) ? PW'(1) : r_pkt + 1'b1;
        if (MaxPktLen != 0 && w_pkt == PW'(MaxPktLen)) begin
          w_too_long = 1'b1;
          w_state = IDLE;
          w_rr = nxt(w_gidx);
          w_pkt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_rr <= '0;
      r_owner <= '0;
      r_pkt <= '0;
    end else begin
      r_state <= w_state;
      r_rr <= w_rr;
      r_owner <= w_owner;
      r_pkt <= w_pkt;
    end
  end

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
    logic w_send, w_cred;
    assign w_send = w_gnt[v];
    assign w_cred = bus.credit_i[v];
    assign w_elig[v] = bus.valid_i[v] & (r_cnt[v] != '0);
    assign bus.credit_left_o[v] = r_cnt[v] != '0;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_cnt[v] <= CW'(NumCredits);
      else if (w_send && !w_cred) r_cnt[v] <= r_cnt[v] - 1'b1;
      else if (w_cred && !w_send && r_cnt[v] != CW'(NumCredits)) r_cnt[v] <= r_cnt[v] + 1'b1;
    end
    CreditOverflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_cred && !w_send && r_cnt[v] == CW'(NumCredits)));
`ifdef FLOO_VC_SCHED_STATS_EN
    logic [15:0] r_stall;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_stall <= '0;
      else if (bus.valid_i[v] && !w_send && r_stall != 16'hFFFF) r_stall <= r_stall + 1'b1;
    end
    assign bus.stall_cnt_o[v] = r_stall;
`else
    assign bus.stall_cnt_o[v] = '0;
`endif
  end

  PktTooLong: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_too_long);
  ValidOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(bus.valid_o));
  ValidSubset: assert property (@(posedge clk_i) disable iff (!rst_ni) (bus.valid_o & ~bus.valid_i) == '0);
endmodule

// File: tb/tb_floo_vc_credit_scheduler.sv
// tb_floo_vc_credit_scheduler: directed scoreboard bench for the VC credit scheduler (N=2, 3 credits).
module tb_floo_vc_credit_scheduler;
  typedef logic [7:0] flit_t;
  typedef struct packed {logic [1:0] v; flit_t d;} exp_t;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
`ifdef FLOO_VC_SCHED_STATS_EN
  localparam logic [31:0] StallExp = 32'd5;
`else
  localparam logic [31:0] StallExp = 32'd0;
`endif

  always #5 clk_i = ~clk_i;

  floo_vc_credit_scheduler_if #(.NumVirtChannels(2), .flit_t(flit_t)) bus ();
  floo_vc_credit_scheduler #(
    .NumVirtChannels(2), .flit_t(flit_t), .NumCredits(3), .MaxPktLen(0)
  ) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [1:0] c,
                       input flit_t d0, input flit_t d1);
    bus.valid_i = v;
    bus.last_i = l;
    bus.credit_i = c;
    bus.data_i[0] = d0;
    bus.data_i[1] = d1;
  endtask

  // Expected link output is queued with the stimulus and popped at the sampling edge.
  task automatic tick(input string tag, input logic [1:0] ev, input flit_t ed);
    exp_t e;
    sb.push_back('{v: ev, d: ed});
    @(negedge clk_i);
    e = sb.pop_front();
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'(e.v));
    chk({tag, ".ready"}, 32'(bus.ready_o), 32'(e.v));
    if (e.v != 2'b00) chk({tag, ".data"}, 32'(bus.data_o), 32'(e.d));
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [1:0] ev;
    do_reset();
    chk("rst.credit_left", 32'(bus.credit_left_o), 32'h3);
    chk("rst.valid", 32'(bus.valid_o), 32'h0);
    chk("rst.stall1", 32'(bus.stall_cnt_o[1]), 32'h0);

    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 2'b01, 2'b00, flit_t'(8'h10 + i), 8'h00);
      tick("t1.send", 2'b01, flit_t'(8'h10 + i));
    end
    chk("t1.credit_empty", 32'(bus.credit_left_o), 32'h2);
    drive(2'b01, 2'b01, 2'b00, 8'h13, 8'h00);
    tick("t1.stall", 2'b00, 8'h00);
    drive(2'b01, 2'b01, 2'b01, 8'h13, 8'h00);
    tick("t1.credit", 2'b00, 8'h00);
    drive(2'b01, 2'b01, 2'b00, 8'h13, 8'h00);
    tick("t1.resume", 2'b01, 8'h13);
    chk("t1.credit_after", 32'(bus.credit_left_o), 32'h2);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      ev = (i % 2 == 1) ? 2'b10 : 2'b01;
      drive(2'b11, 2'b11, ev, 8'hA0, 8'hB0);
      tick("t2.rr", ev, (i % 2 == 1) ? 8'hB0 : 8'hA0);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, {1'b1, i == 3}, 2'b01, flit_t'(8'h31 + i), 8'h55);
      tick("t3.lock", 2'b01, flit_t'(8'h31 + i));
    end
    drive(2'b10, 2'b10, 2'b10, 8'h00, 8'h55);
    tick("t3.vc1", 2'b10, 8'h55);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b10, 2'b00, flit_t'(8'h40 + i), 8'h66);
      tick("t4.send", 2'b01, flit_t'(8'h40 + i));
    end
    chk("t4.credit_empty", 32'(bus.credit_left_o), 32'h2);
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 2'b10, 2'b00, 8'h43, 8'h66);
      tick("t4.block", 2'b00, 8'h00);
    end
    drive(2'b11, 2'b10, 2'b01, 8'h43, 8'h66);
    tick("t4.credit", 2'b00, 8'h00);
    drive(2'b11, 2'b11, 2'b00, 8'h43, 8'h66);
    tick("t4.resume", 2'b01, 8'h43);
    drive(2'b10, 2'b10, 2'b10, 8'h00, 8'h66);
    tick("t4.vc1", 2'b10, 8'h66);

    do_reset();
    drive(2'b01, 2'b01, 2'b00, 8'h50, 8'h00);
    tick("t5.send", 2'b01, 8'h50);
    drive(2'b01, 2'b01, 2'b01, 8'h51, 8'h00);
    tick("t5.both", 2'b01, 8'h51);
    drive(2'b01, 2'b01, 2'b00, 8'h52, 8'h00);
    tick("t5.drain", 2'b01, 8'h52);
    chk("t5.credit_one", 32'(bus.credit_left_o), 32'h3);
    drive(2'b01, 2'b01, 2'b00, 8'h53, 8'h00);
    tick("t5.drain", 2'b01, 8'h53);
    chk("t5.credit_zero", 32'(bus.credit_left_o), 32'h2);
    drive(2'b01, 2'b01, 2'b00, 8'h54, 8'h00);
    tick("t5.stall", 2'b00, 8'h00);

    do_reset();
    drive(2'b01, 2'b00, 2'b01, 8'h70, 8'h00);
    tick("t6.head", 2'b01, 8'h70);
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, {1'b1, i == 4}, 2'b01, flit_t'(8'h71 + i), 8'h77);
      tick("t6.lock", 2'b01, flit_t'(8'h71 + i));
    end
    chk("t6.stall1", 32'(bus.stall_cnt_o[1]), StallExp);
    drive(2'b10, 2'b10, 2'b10, 8'h00, 8'h77);
    tick("t6.vc1", 2'b10, 8'h77);
    chk("t6.stall1_hold", 32'(bus.stall_cnt_o[1]), StallExp);
    chk("t6.stall0", 32'(bus.stall_cnt_o[0]), 32'h0);

    drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
